// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce controller.
// One shared compare/increment engine visits one channel per clock in
// round-robin order. Each channel keeps a candidate level and a small
// stability counter. When a channel's debounced level changes, an event
// (channel, direction) is offered on a one-entry valid/ready register.
//
// Handshake: ev_valid/ev_channel/ev_rise form one event. The event is
// transferred on a clock edge where ev_valid && ev_ready. While ev_valid is
// high and ev_ready is low, ev_channel and ev_rise hold steady. A new event
// that arrives while the register is full and not being drained is dropped
// and sets the sticky ovf flag (the clean level still updates).
module debounce_scan_ctrl #(
  parameter int N             = 8,
  parameter int STABLE_VISITS = 81250,
  parameter int CW            = 17,
  parameter int IW            = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  noisy,
  output logic [N-1:0]  clean,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [IW-1:0] ev_channel,
  output logic          ev_rise,
  output logic          ovf,
  input  logic          ovf_clear
);

  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_VISITS);
  localparam logic [IW-1:0] PTR_LAST   = IW'(N - 1);

  logic [N-1:0]  s1_q, s1_d;
  logic [N-1:0]  s2_q, s2_d;
  logic [N-1:0]  cand_q, cand_d;
  logic [N-1:0]  clean_q, clean_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [IW-1:0] ptr_q, ptr_d;
  logic          ev_valid_q, ev_valid_d;
  logic [IW-1:0] ev_channel_q, ev_channel_d;
  logic          ev_rise_q, ev_rise_d;
  logic          ovf_q, ovf_d;

  logic          edge_ev;
  logic          drop;
  logic          vis_s2;
  logic          vis_cand;
  logic [CW-1:0] vis_cnt;

  // Two-flop synchronizer and explicit-wrap scan pointer.
  always_comb begin
    s1_d  = noisy;
    s2_d  = s1_q;
    ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + IW'(1);
  end

  // Shared engine: update the one channel addressed by ptr_q.
  always_comb begin
    cand_d   = cand_q;
    clean_d  = clean_q;
    cnt_d    = cnt_q;
    edge_ev  = 1'b0;
    vis_s2   = s2_q[ptr_q];
    vis_cand = cand_q[ptr_q];
    vis_cnt  = cnt_q[ptr_q];
    if (vis_s2 != vis_cand) begin
      // Input moved since last visit: restart the stability count.
      cand_d[ptr_q] = vis_s2;
      cnt_d[ptr_q]  = '0;
    end else if (vis_cnt == STABLE_CNT) begin
      // Stable long enough: commit; counter saturates here.
      clean_d[ptr_q] = vis_cand;
      edge_ev        = (clean_q[ptr_q] != vis_cand);
    end else begin
      cnt_d[ptr_q] = vis_cnt + CW'(1);
    end
  end

  // One-entry event register with drop detection and sticky overflow.
  always_comb begin
    ev_valid_d   = ev_valid_q;
    ev_channel_d = ev_channel_q;
    ev_rise_d    = ev_rise_q;
    ovf_d        = ovf_q;
    drop         = 1'b0;
    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (edge_ev) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d   = 1'b1;
        ev_channel_d = ptr_q;
        ev_rise_d    = vis_cand;
      end else begin
        drop = 1'b1;
      end
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset loads the raw input so no event is produced.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q         <= noisy;
      s2_q         <= noisy;
      cand_q       <= noisy;
      clean_q      <= noisy;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      ptr_q        <= '0;
      ev_valid_q   <= 1'b0;
      ev_channel_q <= '0;
      ev_rise_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cand_q       <= cand_d;
      clean_q      <= clean_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      ptr_q        <= ptr_d;
      ev_valid_q   <= ev_valid_d;
      ev_channel_q <= ev_channel_d;
      ev_rise_q    <= ev_rise_d;
      ovf_q        <= ovf_d;
    end
  end

  assign clean      = clean_q;
  assign ev_valid   = ev_valid_q;
  assign ev_channel = ev_channel_q;
  assign ev_rise    = ev_rise_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl with N=4, STABLE_VISITS=3.
// Edge k after reset release visits channel (k-1)%4; a change on noisy
// applied after edge a is first seen by a visit at edge >= a+3.
module tb_debounce_scan_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] noisy;
  logic [3:0] clean;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_channel;
  logic       ev_rise;
  logic       ovf;
  logic       ovf_clear;

  int         tests;
  int         fails;
  int         edge_n;
  logic [3:0] exp_clean;

  typedef struct {
    int         rel;
    logic [3:0] noisy;
    logic       ready;
    logic       clr;
    logic [3:0] e_clean;
    logic       e_valid;
    logic [1:0] e_ch;
    logic       e_rise;
    logic       e_ovf;
  } row_t;

  row_t tbl [10];

  debounce_scan_ctrl #(
    .N(4), .STABLE_VISITS(3), .CW(2), .IW(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .noisy(noisy),
    .clean(clean),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_channel(ev_channel),
    .ev_rise(ev_rise),
    .ovf(ovf),
    .ovf_clear(ovf_clear)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic run_plain(input int target);
    while (edge_n < target) tick();
  endtask

  // Advance to target, requiring clean to hold and no event to appear.
  task automatic run_quiet(input int target, input string name);
    logic bad;
    bad = 1'b0;
    while (edge_n < target) begin
      tick();
      if (ev_valid !== 1'b0 || clean !== exp_clean) bad = 1'b1;
    end
    chk(name, {31'd0, bad}, 32'd0);
  endtask

  task automatic align(input int ph);
    while (edge_n % 4 != ph) tick();
  endtask

  // noisy[ch] was set to val right after edge a; check the resulting event.
  task automatic single_edge(input int ch, input logic val, input int a, input string tag);
    int k;
    k = a + 3;
    while ((k - 1) % 4 != ch) k++;
    run_quiet(k + 15, {tag, "_quiet"});
    chk({tag, "_pre_clean"}, clean, exp_clean);
    tick();
    exp_clean[ch] = val;
    chk({tag, "_clean"}, clean, exp_clean);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_chan"}, ev_channel, ch);
    chk({tag, "_rise"}, ev_rise, val);
    tick();
    chk({tag, "_valid_drop"}, ev_valid, 0);
  endtask

  initial begin
    logic bad;
    int   a;
    tests     = 0;
    fails     = 0;
    edge_n    = 0;
    reset     = 1'b1;
    noisy     = 4'b0101;
    ev_ready  = 1'b1;
    ovf_clear = 1'b0;

    // Test 4 timeline, offsets from an edge a with a%4 == 2.
    tbl[0] = '{0,  4'b1110, 1'b0, 1'b0, 4'b0111, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{18, 4'b1110, 1'b0, 1'b0, 4'b0111, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{19, 4'b1110, 1'b0, 1'b0, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[3] = '{21, 4'b1110, 1'b0, 1'b0, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[4] = '{22, 4'b1110, 1'b0, 1'b1, 4'b1110, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[5] = '{23, 4'b0110, 1'b0, 1'b0, 4'b1110, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{41, 4'b0110, 1'b0, 1'b1, 4'b1110, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{42, 4'b0110, 1'b1, 1'b0, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[8] = '{43, 4'b0110, 1'b1, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[9] = '{44, 4'b0110, 1'b1, 1'b0, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0};

    // Test 1: reset loads raw input, no event, no ovf.
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clean !== 4'b0101 || ev_valid !== 1'b0 || ovf !== 1'b0) bad = 1'b1;
    end
    chk("t1_reset_hold", {31'd0, bad}, 32'd0);
    chk("t1_clean", clean, 4'b0101);
    exp_clean = 4'b0101;
    reset  = 1'b0;
    edge_n = 0;

    // Test 2: ch2 fall then rise, consumer always ready.
    noisy = 4'b0001;
    single_edge(2, 1'b0, edge_n, "t2_fall");
    noisy = 4'b0101;
    single_edge(2, 1'b1, edge_n, "t2_rise");

    // Test 3: ch1 bounces every 6 clocks, then settles high.
    bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      noisy[1] = ~noisy[1];
      for (int c = 0; c < 6; c++) begin
        tick();
        if (clean !== exp_clean || ev_valid !== 1'b0) bad = 1'b1;
      end
    end
    chk("t3_bounce_quiet", {31'd0, bad}, 32'd0);
    noisy[1] = 1'b1;
    single_edge(1, 1'b1, edge_n, "t3_settle");

    // Test 4: held event, drop, ovf clear, set-wins clear.
    align(2);
    a = edge_n;
    for (int r = 0; r < 10; r++) begin
      run_plain(a + tbl[r].rel);
      chk($sformatf("t4_r%0d_clean", r), clean, tbl[r].e_clean);
      chk($sformatf("t4_r%0d_valid", r), ev_valid, tbl[r].e_valid);
      chk($sformatf("t4_r%0d_ovf", r), ovf, tbl[r].e_ovf);
      if (tbl[r].e_valid) begin
        chk($sformatf("t4_r%0d_chan", r), ev_channel, tbl[r].e_ch);
        chk($sformatf("t4_r%0d_rise", r), ev_rise, tbl[r].e_rise);
      end
      noisy     = tbl[r].noisy;
      ev_ready  = tbl[r].ready;
      ovf_clear = tbl[r].clr;
    end
    exp_clean = 4'b0110;

    // Test 5: back-to-back events on ch0 then ch1.
    align(2);
    a = edge_n;
    noisy = 4'b0101;
    run_quiet(a + 18, "t5_quiet");
    tick();
    chk("t5_e0_valid", ev_valid, 1);
    chk("t5_e0_chan", ev_channel, 0);
    chk("t5_e0_rise", ev_rise, 1);
    chk("t5_e0_clean", clean, 4'b0111);
    tick();
    chk("t5_e1_valid", ev_valid, 1);
    chk("t5_e1_chan", ev_channel, 1);
    chk("t5_e1_rise", ev_rise, 0);
    chk("t5_e1_clean", clean, 4'b0101);
    chk("t5_e1_ovf", ovf, 0);
    tick();
    chk("t5_idle_valid", ev_valid, 0);
    exp_clean = 4'b0101;

    // Test 6: reset while ch3 is mid-count.
    a = edge_n;
    noisy = 4'b1101;
    begin
      int k;
      k = a + 3;
      while ((k - 1) % 4 != 3) k++;
      run_quiet(k + 9, "t6_pre_quiet");
    end
    reset = 1'b1;
    tick();
    chk("t6_rst_clean", clean, 4'b1101);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_ovf", ovf, 0);
    tick();
    reset     = 1'b0;
    edge_n    = 0;
    exp_clean = 4'b1101;
    // Event timing on ch0 proves the pointer restarted at 0.
    noisy = 4'b1100;
    single_edge(0, 1'b0, edge_n, "t6_ptr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
